// File: rtl/prog_seq_if.sv
// rtl/prog_seq_if.sv - control and status bundle for the program sequencer
interface prog_seq_if #(
    parameter int instr_width = 9,
    parameter int reg_width   = 8,
    parameter int stack_depth = 4
);
    localparam int SPW = $clog2(stack_depth) + 1;

    logic [instr_width-1:0] start_addr;
    logic                   stall;
    logic                   branch;
    logic                   taken;
    logic                   rel_mode;
    logic [reg_width-1:0]   target;
    logic                   call;
    logic                   ret;
    logic                   halt_req;
    logic [instr_width-1:0] pc_out;
    logic [SPW-1:0]         sp_out;
    logic                   halted;
    logic                   stack_err;

    modport master (
        output start_addr, stall, branch, taken, rel_mode, target, call, ret, halt_req,
        input  pc_out, sp_out, halted, stack_err
    );

    modport slave (
        input  start_addr, stall, branch, taken, rel_mode, target, call, ret, halt_req,
        output pc_out, sp_out, halted, stack_err
    );
endinterface

// File: rtl/prog_seq.sv
// rtl/prog_seq.sv - program counter sequencer with branch, call/return stack and halt
module prog_seq #(
    parameter int instr_width = 9,
    parameter int reg_width   = 8,
    parameter int stack_depth = 4
) (
    input logic       clk,
    input logic       start,
    prog_seq_if.slave bus
);
    localparam int AW  = $clog2(stack_depth);
    localparam int SPW = AW + 1;
    localparam logic [SPW-1:0] DEPTH = SPW'(stack_depth);

    typedef enum logic {RUN, HALT} state_t;

    state_t                 state_q;
    logic [instr_width-1:0] pc_q;
    logic [SPW-1:0]         sp_q;
    logic                   err_q;
    logic [instr_width-1:0] stack_q [stack_depth];

    logic [instr_width-1:0] pc_inc;
    logic [instr_width-1:0] eff_target;
    logic [SPW-1:0]         sp_dec;
    logic [AW-1:0]          push_idx;
    logic [AW-1:0]          pop_idx;

    // Relative targets are sign-extended so negative offsets branch backwards.
    assign pc_inc     = pc_q + instr_width'(1);
    assign eff_target = bus.rel_mode ? pc_q + instr_width'($signed(bus.target))
                                     : instr_width'(bus.target);
    assign sp_dec     = sp_q - SPW'(1);
    assign push_idx   = sp_q[AW-1:0];
    assign pop_idx    = sp_dec[AW-1:0];

    always_ff @(posedge clk) begin
        if (start) begin
            state_q <= RUN;
            pc_q    <= bus.start_addr;
            sp_q    <= '0;
            err_q   <= 1'b0;
        end else if (state_q == RUN && !bus.stall) begin
            if (bus.halt_req) begin
                state_q <= HALT;
            end else if (bus.ret) begin
                if (sp_q != '0) begin
                    pc_q <= stack_q[pop_idx];
                    sp_q <= sp_dec;
                end else begin
                    err_q <= 1'b1;
                    pc_q  <= pc_inc;
                end
            end else if (bus.call) begin
                if (sp_q < DEPTH) begin
                    stack_q[push_idx] <= pc_inc;
                    sp_q              <= sp_q + SPW'(1);
                    pc_q              <= eff_target;
                end else begin
                    err_q <= 1'b1;
                    pc_q  <= pc_inc;
                end
            end else if (bus.branch && bus.taken) begin
                pc_q <= eff_target;
            end else begin
                pc_q <= pc_inc;
            end
        end
    end

    assign bus.pc_out    = pc_q;
    assign bus.sp_out    = sp_q;
    assign bus.halted    = (state_q == HALT);
    assign bus.stack_err = err_q;
endmodule

// File: tb/tb_prog_seq.sv
// tb/tb_prog_seq.sv - directed self-checking bench for prog_seq
module tb_prog_seq;
    logic clk;
    logic start;
    int   n_checks;
    int   n_fail;

    prog_seq_if #(.instr_width(9), .reg_width(8), .stack_depth(4)) bus ();

    prog_seq #(.instr_width(9), .reg_width(8), .stack_depth(4)) dut (
        .clk   (clk),
        .start (start),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.stall    = 1'b0;
        bus.branch   = 1'b0;
        bus.taken    = 1'b0;
        bus.rel_mode = 1'b0;
        bus.target   = 8'h00;
        bus.call     = 1'b0;
        bus.ret      = 1'b0;
        bus.halt_req = 1'b0;
    endtask

    task automatic restart(input logic [8:0] addr);
        idle_inputs();
        start          = 1'b1;
        bus.start_addr = addr;
        step();
        start = 1'b0;
    endtask

    task automatic test_reset();
        restart(9'h010);
        n_checks++; if (bus.pc_out !== 9'h010) begin n_fail++; $display("FAIL reset_pc: got %h expected 010", bus.pc_out); end
        n_checks++; if (bus.sp_out !== 3'd0) begin n_fail++; $display("FAIL reset_sp: got %0d expected 0", bus.sp_out); end
        n_checks++; if (bus.halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted: got %b expected 0", bus.halted); end
        n_checks++; if (bus.stack_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", bus.stack_err); end
        for (int i = 1; i <= 3; i++) begin
            step();
            n_checks++; if (bus.pc_out !== 9'h010 + 9'(i)) begin n_fail++; $display("FAIL idle_pc[%0d]: got %h expected %h", i, bus.pc_out, 9'h010 + 9'(i)); end
        end
        n_checks++; if (bus.sp_out !== 3'd0) begin n_fail++; $display("FAIL idle_sp: got %0d expected 0", bus.sp_out); end
    endtask

    task automatic test_branch();
        restart(9'h020);
        bus.branch = 1'b1; bus.taken = 1'b1; bus.rel_mode = 1'b1; bus.target = 8'hFC;
        step();
        n_checks++; if (bus.pc_out !== 9'h01C) begin n_fail++; $display("FAIL branch_rel_neg: got %h expected 01C", bus.pc_out); end
        bus.rel_mode = 1'b0; bus.target = 8'h80;
        step();
        n_checks++; if (bus.pc_out !== 9'h080) begin n_fail++; $display("FAIL branch_abs: got %h expected 080", bus.pc_out); end
        bus.taken = 1'b0; bus.target = 8'h33;
        step();
        n_checks++; if (bus.pc_out !== 9'h081) begin n_fail++; $display("FAIL branch_not_taken: got %h expected 081", bus.pc_out); end
        bus.taken = 1'b1; bus.stall = 1'b1;
        step();
        n_checks++; if (bus.pc_out !== 9'h081) begin n_fail++; $display("FAIL stall_hold: got %h expected 081", bus.pc_out); end
        idle_inputs();
    endtask

    task automatic test_wrap();
        restart(9'h1FF);
        step();
        n_checks++; if (bus.pc_out !== 9'h000) begin n_fail++; $display("FAIL wrap_inc: got %h expected 000", bus.pc_out); end
        restart(9'h1FF);
        bus.branch = 1'b1; bus.taken = 1'b1; bus.rel_mode = 1'b1; bus.target = 8'h02;
        step();
        n_checks++; if (bus.pc_out !== 9'h001) begin n_fail++; $display("FAIL wrap_rel: got %h expected 001", bus.pc_out); end
        idle_inputs();
    endtask

    task automatic test_calls();
        logic [8:0] exp_pc [4];
        logic [2:0] exp_sp [4];
        exp_pc[0] = 9'h040; exp_pc[1] = 9'h060; exp_pc[2] = 9'h041; exp_pc[3] = 9'h006;
        exp_sp[0] = 3'd1;   exp_sp[1] = 3'd2;   exp_sp[2] = 3'd1;   exp_sp[3] = 3'd0;
        restart(9'h005);
        for (int i = 0; i < 4; i++) begin
            idle_inputs();
            if (i < 2) begin
                bus.call   = 1'b1;
                bus.target = (i == 0) ? 8'h40 : 8'h60;
            end else begin
                bus.ret = 1'b1;
            end
            step();
            n_checks++; if (bus.pc_out !== exp_pc[i]) begin n_fail++; $display("FAIL nest_pc[%0d]: got %h expected %h", i, bus.pc_out, exp_pc[i]); end
            n_checks++; if (bus.sp_out !== exp_sp[i]) begin n_fail++; $display("FAIL nest_sp[%0d]: got %0d expected %0d", i, bus.sp_out, exp_sp[i]); end
        end
        restart(9'h100);
        bus.call = 1'b1; bus.target = 8'h50;
        step();
        bus.ret = 1'b1; bus.target = 8'h70;
        step();
        n_checks++; if (bus.pc_out !== 9'h101) begin n_fail++; $display("FAIL call_ret_pc: got %h expected 101", bus.pc_out); end
        n_checks++; if (bus.sp_out !== 3'd0) begin n_fail++; $display("FAIL call_ret_sp: got %0d expected 0", bus.sp_out); end
        idle_inputs();
    endtask

    task automatic test_overflow();
        logic [8:0] exp_pop [4];
        exp_pop[0] = 9'h011; exp_pop[1] = 9'h011; exp_pop[2] = 9'h011; exp_pop[3] = 9'h001;
        restart(9'h000);
        bus.call = 1'b1; bus.target = 8'h10;
        for (int i = 0; i < 4; i++) step();
        n_checks++; if (bus.sp_out !== 3'd4 || bus.pc_out !== 9'h010) begin n_fail++; $display("FAIL fill: got sp %0d pc %h expected sp 4 pc 010", bus.sp_out, bus.pc_out); end
        n_checks++; if (bus.stack_err !== 1'b0) begin n_fail++; $display("FAIL fill_err: got %b expected 0", bus.stack_err); end
        step();
        n_checks++; if (bus.pc_out !== 9'h011) begin n_fail++; $display("FAIL ovf_pc: got %h expected 011", bus.pc_out); end
        n_checks++; if (bus.stack_err !== 1'b1 || bus.sp_out !== 3'd4) begin n_fail++; $display("FAIL ovf_state: got err %b sp %0d expected err 1 sp 4", bus.stack_err, bus.sp_out); end
        bus.call = 1'b0; bus.ret = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            n_checks++; if (bus.pc_out !== exp_pop[i]) begin n_fail++; $display("FAIL pop_pc[%0d]: got %h expected %h", i, bus.pc_out, exp_pop[i]); end
        end
        step();
        n_checks++; if (bus.pc_out !== 9'h002 || bus.sp_out !== 3'd0) begin n_fail++; $display("FAIL udf: got pc %h sp %0d expected pc 002 sp 0", bus.pc_out, bus.sp_out); end
        n_checks++; if (bus.stack_err !== 1'b1) begin n_fail++; $display("FAIL udf_err: got %b expected 1", bus.stack_err); end
        idle_inputs();
    endtask

    task automatic test_halt();
        restart(9'h02F);
        bus.ret = 1'b1;
        step();
        n_checks++; if (bus.pc_out !== 9'h030 || bus.stack_err !== 1'b1) begin n_fail++; $display("FAIL pre_halt: got pc %h err %b expected pc 030 err 1", bus.pc_out, bus.stack_err); end
        bus.ret = 1'b0; bus.stall = 1'b1; bus.halt_req = 1'b1;
        step();
        n_checks++; if (bus.halted !== 1'b0 || bus.pc_out !== 9'h030) begin n_fail++; $display("FAIL stall_halt: got halted %b pc %h expected halted 0 pc 030", bus.halted, bus.pc_out); end
        bus.stall = 1'b0;
        step();
        n_checks++; if (bus.halted !== 1'b1 || bus.pc_out !== 9'h030) begin n_fail++; $display("FAIL halt_enter: got halted %b pc %h expected halted 1 pc 030", bus.halted, bus.pc_out); end
        bus.halt_req = 1'b0; bus.branch = 1'b1; bus.taken = 1'b1; bus.target = 8'h77; bus.call = 1'b1;
        step();
        step();
        n_checks++; if (bus.pc_out !== 9'h030 || bus.sp_out !== 3'd0) begin n_fail++; $display("FAIL halt_hold: got pc %h sp %0d expected pc 030 sp 0", bus.pc_out, bus.sp_out); end
        n_checks++; if (bus.halted !== 1'b1 || bus.stack_err !== 1'b1) begin n_fail++; $display("FAIL halt_flags: got halted %b err %b expected 1 1", bus.halted, bus.stack_err); end
        start = 1'b1; bus.start_addr = 9'h0AA;
        step();
        start = 1'b0;
        n_checks++; if (bus.pc_out !== 9'h0AA || bus.halted !== 1'b0 || bus.stack_err !== 1'b0) begin n_fail++; $display("FAIL halt_restart: got pc %h halted %b err %b expected 0AA 0 0", bus.pc_out, bus.halted, bus.stack_err); end
        idle_inputs();
    endtask

    task automatic test_back_to_back();
        restart(9'h000);
        bus.call = 1'b1; bus.target = 8'h40;
        step();
        step();
        start = 1'b1; bus.start_addr = 9'h123;
        step();
        start = 1'b0;
        n_checks++; if (bus.pc_out !== 9'h123 || bus.sp_out !== 3'd0) begin n_fail++; $display("FAIL restart_mid_call: got pc %h sp %0d expected 123 0", bus.pc_out, bus.sp_out); end
        idle_inputs();
        step();
        n_checks++; if (bus.pc_out !== 9'h124) begin n_fail++; $display("FAIL restart_resume: got %h expected 124", bus.pc_out); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        start    = 1'b1;
        bus.start_addr = 9'h000;
        idle_inputs();
        test_reset();
        test_branch();
        test_wrap();
        test_calls();
        test_overflow();
        test_halt();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
